pipe_stage_skid_reg: RTL

Parametrised pipeline stage register, the successor to the fixed ID/EX latch. It carries an arbitrary-width payload between pipeline stages using a valid/ready handshake. A 2-entry skid buffer gives full throughput under back-pressure with a registered in_ready. Flush produces a bubble whose control field is forced to zero, so downstream logic that ignores valid still sees a NOP.

---
 rtl/pipe_stage_skid_reg_pkg.sv | 40 ++++
 rtl/pipe_entry_reg.sv | 49 ++++
 rtl/pipe_stage_skid_reg.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_stage_skid_reg_pkg.sv
// rtl/pipe_stage_skid_reg_pkg.sv - shared pipeline payload helpers
package pipe_stage_skid_reg_pkg;

    // Widest payload the bubble helper can handle.
    // Callers zero-extend their payload to this width and slice the result back.
    localparam int PKG_MAX_W = 1024;

    // Per-entry update request.
    // DRAIN empties the entry and zeroes only the control field.
    // CLEAR is the reset/flush form, which can also wipe the data bits.
    typedef enum logic [1:0] {
        ENTRY_HOLD  = 2'd0,
        ENTRY_LOAD  = 2'd1,
        ENTRY_DRAIN = 2'd2,
        ENTRY_CLEAR = 2'd3
    } entry_op_e;

    // The control field sits MSB-aligned in the payload.
    // This returns the bit index of its LSB.
    function automatic int ctrl_lsb(input int data_w, input int ctrl_w);
        return data_w - ctrl_w;
    endfunction

    // Build a bubble from a payload.
    // The control field is always forced to zero.
    // When clear_data is set, the remaining bits are zeroed as well.
    function automatic logic [PKG_MAX_W-1:0] make_bubble(
        input logic [PKG_MAX_W-1:0] payload,
        input int                   data_w,
        input int                   ctrl_w,
        input bit                   clear_data
    );
        logic [PKG_MAX_W-1:0] ones;
        logic [PKG_MAX_W-1:0] mask;
        ones = '1;
        mask = (ones >> (PKG_MAX_W - ctrl_w)) << ctrl_lsb(data_w, ctrl_w);
        return clear_data ? '0 : (payload & ~mask);
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one valid+payload register of the pipeline stage
module pipe_entry_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int DATA_W     = 183,
    parameter int CTRL_W     = 8,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  entry_op_e         op,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic [PKG_MAX_W-1:0] drain_wide;
    logic [PKG_MAX_W-1:0] clear_wide;

    // Going empty in normal flow keeps stale data but must still read as a NOP.
    assign drain_wide = make_bubble(PKG_MAX_W'(data), DATA_W, CTRL_W, 1'b0);
    assign clear_wide = make_bubble(PKG_MAX_W'(data), DATA_W, CTRL_W, CLEAR_DATA);

    // Upper bits beyond DATA_W are always zero; fold them away.
    logic unused_hi;
    assign unused_hi = ^{drain_wide[PKG_MAX_W-1:DATA_W], clear_wide[PKG_MAX_W-1:DATA_W]};

    // Entry state update according to the requested operation.
    always_ff @(posedge clk) begin
        case (op)
            ENTRY_LOAD: begin
                valid <= 1'b1;
                data  <= load_data;
            end
            ENTRY_DRAIN: begin
                valid <= 1'b0;
                data  <= drain_wide[DATA_W-1:0];
            end
            ENTRY_CLEAR: begin
                valid <= 1'b0;
                data  <= clear_wide[DATA_W-1:0];
            end
            default: begin
                valid <= valid;
                data  <= data;
            end
        endcase
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - valid/ready pipeline stage with 2-entry skid buffer
module pipe_stage_skid_reg
    import pipe_stage_skid_reg_pkg::*;
#(
    parameter int DATA_W     = 183,
    parameter int CTRL_W     = 8,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;

    entry_op_e         main_op;
    entry_op_e         skid_op;
    logic [DATA_W-1:0] main_load;

    logic accept;
    logic consume;

    // in_ready comes straight from the skid flop, so it has no combinational path from out_ready.
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

    // Select per-entry operations for this edge.
    // Reset and flush win over any handshake.
    always_comb begin
        main_op   = ENTRY_HOLD;
        skid_op   = ENTRY_HOLD;
        main_load = in_data;
        if (rst || flush) begin
            main_op = ENTRY_CLEAR;
            skid_op = ENTRY_CLEAR;
        end else if (!main_valid) begin
            // Skid is necessarily empty here.
            if (accept) begin
                main_op = ENTRY_LOAD;
            end
        end else if (consume) begin
            if (skid_valid) begin
                // The older skid beat moves up.
                // in_ready is low, so nothing new arrives this cycle.
                main_op   = ENTRY_LOAD;
                main_load = skid_data;
                skid_op   = ENTRY_DRAIN;
            end else if (accept) begin
                main_op = ENTRY_LOAD;
            end else begin
                main_op = ENTRY_DRAIN;
            end
        end else if (accept) begin
            // Stalled with main full: park the new beat in skid.
            skid_op = ENTRY_LOAD;
        end
    end

    pipe_entry_reg #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk       (clk),
        .op        (main_op),
        .load_data (main_load),
        .valid     (main_valid),
        .data      (main_data)
    );

    pipe_entry_reg #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk       (clk),
        .op        (skid_op),
        .load_data (in_data),
        .valid     (skid_valid),
        .data      (skid_data)
    );

endmodule
